// File: rtl/odd_parity_serial_tx.sv
// ----------------------------------------------------------------------------
// odd_parity_serial_tx
//
// Serialiser that accepts a parallel word over a valid/ready handshake and
// sends it as one framed serial line: a start bit (0), the data bits LSB
// first, an odd parity bit, and a stop bit (1). Each bit is held on the line
// for CLKS_PER_BIT clock cycles. The parity bit is the XNOR-reduce of the
// data bits, so data plus parity always contain an odd number of ones.
//
// Parameters:
//   DATA_W        number of data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//
// Ports:
//   clk       input   system clock, rising edge
//   rst_n     input   asynchronous active-low reset
//   in_data   input   word to transmit, sampled only on an accepted handshake
//   in_valid  input   in_data is valid
//   in_ready  output  block can accept a word this cycle (state is IDLE)
//   tx        output  serial line, registered, idles at 1
//   busy      output  a frame is in progress (state is not IDLE)
// ----------------------------------------------------------------------------
module odd_parity_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy
);

    // Counters are at least one bit wide so the single-cycle-per-bit and
    // single-data-bit configurations still have a legal register.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     clk_cnt_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              par_q;
    logic              tx_q;
    logic              busy_q;
    logic              ready_q;
    logic              clk_last;

    // Next shift-register value and the end-of-bit-period strobe. The line
    // value for the next data bit is taken from the already-shifted word so
    // that a one-bit data path never indexes past the top of the register.
    always_comb begin
        shift_d  = shift_q >> 1;
        clk_last = (clk_cnt_q == CLK_LAST);
    end

    // Frame sequencer. Every output is registered here, and the value loaded
    // into tx_q is the level for the bit period that starts on the next cycle,
    // so tx changes exactly on bit boundaries with no combinational path from
    // the inputs. ready_q and busy_q are updated on the same edges as the
    // state so they always mirror IDLE / not-IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q      <= 1'b1;
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (in_valid && ready_q) begin
                        shift_q <= in_data;
                        par_q   <= ~^in_data;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end

                START: begin
                    if (clk_last) begin
                        clk_cnt_q <= '0;
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_last) begin
                        clk_cnt_q <= '0;
                        shift_q   <= shift_d;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= PARITY;
                            tx_q      <= par_q;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= shift_d[0];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                PARITY: begin
                    if (clk_last) begin
                        clk_cnt_q <= '0;
                        state_q   <= STOP;
                        tx_q      <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    tx_q <= 1'b1;
                    if (clk_last) begin
                        clk_cnt_q <= '0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        ready_q   <= 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                    ready_q   <= 1'b1;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign in_ready = ready_q;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// ----------------------------------------------------------------------------
// tb_odd_parity_serial_tx
//
// Self-checking bench for odd_parity_serial_tx. Two instances run from one
// clock: A with DATA_W=8, CLKS_PER_BIT=4 and B with DATA_W=4, CLKS_PER_BIT=1.
// Expected line levels come from a frame model that maps a cycle offset
// within the frame to a bit position and derives the parity from the count of
// ones in the word. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_odd_parity_serial_tx;

    logic       clk;

    logic       rstA_n;
    logic [7:0] inDataA;
    logic       inValidA;
    logic       readyA;
    logic       txA;
    logic       busyA;

    logic       rstB_n;
    logic [3:0] inDataB;
    logic       inValidB;
    logic       readyB;
    logic       txB;
    logic       busyB;

    int         errors = 0;
    int         checks = 0;

    odd_parity_serial_tx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (4)
    ) dutA (
        .clk      (clk),
        .rst_n    (rstA_n),
        .in_data  (inDataA),
        .in_valid (inValidA),
        .in_ready (readyA),
        .tx       (txA),
        .busy     (busyA)
    );

    odd_parity_serial_tx #(
        .DATA_W       (4),
        .CLKS_PER_BIT (1)
    ) dutB (
        .clk      (clk),
        .rst_n    (rstB_n),
        .in_data  (inDataB),
        .in_valid (inValidB),
        .in_ready (readyB),
        .tx       (txB),
        .busy     (busyB)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on a miss counts the error and reports.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: line level at a given cycle offset from the first START
    // cycle, for a word of width w sent at cpb clocks per bit.
    function automatic logic frameBit(input logic [31:0] word, input int w,
                                      input int cpb, input int cyc);
        int b;
        b = cyc / cpb;
        if (b == 0)
            return 1'b0;
        else if (b <= w)
            return word[b-1];
        else if (b == w + 1)
            return (($countones(word[31:0] & ((32'd1 << w) - 1)) % 2) == 0);
        else
            return 1'b1;
    endfunction

    // Send one frame on instance A and check every cycle of it.
    //   glitch   : toggle in_valid and change in_data during the data bits
    //   hold     : keep in_valid high with nextWord after the accept
    //   abortAt  : cycle offset at which to pulse reset mid-frame (-1 = none)
    task automatic applyStimulusA(input logic [7:0] word, input bit glitch,
                                  input bit hold, input logic [7:0] nextWord,
                                  input int abortAt);
        checkOutput("A ready before accept", readyA, 1);
        inDataA  = word;
        inValidA = 1'b1;
        @(negedge clk);
        if (hold) begin
            inDataA = nextWord;
        end else begin
            inValidA = 1'b0;
            inDataA  = 8'($urandom);
        end
        for (int c = 0; c < 44; c++) begin
            if (glitch && c >= 8 && c < 24) begin
                inValidA = c[0];
                inDataA  = ~word ^ c[7:0];
            end else if (glitch && c == 24) begin
                inValidA = 1'b0;
            end
            checkOutput($sformatf("A tx w=%02h c=%0d", word, c), txA,
                        frameBit(32'(word), 8, 4, c));
            checkOutput($sformatf("A busy c=%0d", c), busyA, 1);
            checkOutput($sformatf("A ready c=%0d", c), readyA, 0);
            if (c == abortAt) begin
                rstA_n = 1'b0;
                #1;
                checkOutput("A tx in reset", txA, 1);
                checkOutput("A busy in reset", busyA, 0);
                checkOutput("A ready in reset", readyA, 1);
                @(negedge clk);
                inValidA = 1'b0;
                rstA_n   = 1'b1;
                return;
            end
            @(negedge clk);
        end
        checkOutput("A idle tx", txA, 1);
        checkOutput("A idle ready", readyA, 1);
        checkOutput("A idle busy", busyA, 0);
    endtask

    // Send one frame on instance B and check every cycle of it.
    task automatic applyStimulusB(input logic [3:0] word);
        checkOutput("B ready before accept", readyB, 1);
        inDataB  = word;
        inValidB = 1'b1;
        @(negedge clk);
        inValidB = 1'b0;
        inDataB  = 4'($urandom);
        for (int c = 0; c < 7; c++) begin
            checkOutput($sformatf("B tx w=%0h c=%0d", word, c), txB,
                        frameBit(32'(word), 4, 1, c));
            checkOutput($sformatf("B busy c=%0d", c), busyB, 1);
            checkOutput($sformatf("B ready c=%0d", c), readyB, 0);
            @(negedge clk);
        end
        checkOutput("B idle tx", txB, 1);
        checkOutput("B idle ready", readyB, 1);
        checkOutput("B idle busy", busyB, 0);
    endtask

    // Directed sequence followed by a few random words on each instance.
    initial begin
        rstA_n   = 1'b0;
        rstB_n   = 1'b0;
        inValidA = 1'b1;
        inValidB = 1'b1;
        inDataA  = 8'hA5;
        inDataB  = 4'hB;
        #23;
        checkOutput("A reset tx", txA, 1);
        checkOutput("A reset busy", busyA, 0);
        checkOutput("A reset ready", readyA, 1);
        checkOutput("B reset tx", txB, 1);
        checkOutput("B reset busy", busyB, 0);
        checkOutput("B reset ready", readyB, 1);

        @(negedge clk);
        inValidA = 1'b0;
        inValidB = 1'b0;
        rstA_n   = 1'b1;
        rstB_n   = 1'b1;
        @(negedge clk);
        checkOutput("A post-reset tx", txA, 1);
        checkOutput("A post-reset busy", busyA, 0);
        checkOutput("B post-reset tx", txB, 1);
        checkOutput("B post-reset busy", busyB, 0);

        applyStimulusA(8'h00, 1'b0, 1'b0, 8'h00, -1);
        applyStimulusA(8'hA5, 1'b0, 1'b0, 8'h00, -1);
        applyStimulusA(8'h07, 1'b0, 1'b0, 8'h00, -1);
        applyStimulusA(8'hFF, 1'b0, 1'b0, 8'h00, -1);
        applyStimulusA(8'h01, 1'b0, 1'b0, 8'h00, -1);

        applyStimulusA(8'h3C, 1'b0, 1'b1, 8'hC3, -1);
        applyStimulusA(8'hC3, 1'b0, 1'b0, 8'h00, -1);

        applyStimulusA(8'h96, 1'b1, 1'b0, 8'h00, -1);

        applyStimulusA(8'($urandom), 1'b0, 1'b0, 8'h00, 18);
        checkOutput("A ready after reset", readyA, 1);
        applyStimulusA(8'h55, 1'b0, 1'b0, 8'h00, -1);

        for (int i = 0; i < 4; i++) begin
            applyStimulusA(8'($urandom), 1'b0, 1'b0, 8'h00, -1);
        end

        applyStimulusB(4'b1011);
        for (int i = 0; i < 4; i++) begin
            applyStimulusB(4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
